// File: rtl/latch_bank_arbiter_if.sv
// Requester-side and latch-bank-side signals of latch_bank_arbiter.
// The slave modport is the arbiter; master is the requester/bank environment.
interface latch_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [IW-1:0]                 grant_id;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         latch_d;
    logic                          latch_enable;

    modport master (
        output req, req_data,
        input  ack, grant_id, busy, latch_d, latch_enable
    );

    modport slave (
        input  req, req_data,
        output ack, grant_id, busy, latch_d, latch_enable
    );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter sequencing writes into a shared transparent-latch bank
// as setup -> enable pulse -> hold, acknowledging once the latch has closed.
module latch_bank_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input logic                clk,
    input logic                reset_n,
    latch_bank_arbiter_if.slave bus
);
    localparam int IW     = $clog2(NUM_REQ);
    localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAXC   = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          found;

    // Scan from farthest to nearest so the first requester after ptr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (bus.req[(int'(ptr) + off) % NUM_REQ]) begin
                win   = IW'((int'(ptr) + off) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            ptr              <= IW'(NUM_REQ - 1);
            bus.ack          <= '0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
            bus.latch_d      <= '0;
            bus.latch_enable <= 1'b0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.latch_d  <= bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
                        bus.grant_id <= win;
                        bus.busy     <= 1'b1;
                        cnt          <= SETUP_LD;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        bus.latch_enable <= 1'b1;
                        cnt              <= PULSE_LD;
                        state            <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        bus.latch_enable <= 1'b0;
                        cnt              <= HOLD_LD;
                        state            <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        bus.ack[bus.grant_id] <= 1'b1;
                        state                 <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    bus.busy <= 1'b0;
                    ptr      <= bus.grant_id;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, monitors check timing and acks.
module tb_latch_bank_arbiter;
    localparam int S = 1, P = 2, H = 1;
    localparam int S2 = 2, P2 = 3, H2 = 2;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [3:0] hold_mask = 4'b0000;

    exp_t exp_q[$];
    exp_t exp2[$];
    int   ack_times[$];

    latch_bank_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
    latch_bank_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus2 ();

    latch_bank_arbiter dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    latch_bank_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8),
        .SETUP_CYCLES(S2), .PULSE_CYCLES(P2), .HOLD_CYCLES(H2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural latch banks fed by each arbiter.
    logic [7:0] q = '0;
    logic [7:0] q2 = '0;
    always @(bus.latch_enable or bus.latch_d)   if (bus.latch_enable)  q  = bus.latch_d;
    always @(bus2.latch_enable or bus2.latch_d) if (bus2.latch_enable) q2 = bus2.latch_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Default-parameter monitor.
    int         k = 0;
    logic [7:0] cap = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            k = 0;
        end else begin
            k = bus.busy ? k + 1 : 0;
            if (bus.busy) begin
                chk("enable_window", 32'(bus.latch_enable), (k > S && k <= S + P) ? 32'd1 : 32'd0);
                if (k == 1) begin
                    cap = bus.latch_d;
                    if (exp_q.size() > 0) begin
                        chk("grant_id", 32'(bus.grant_id), 32'(exp_q[0].id));
                        chk("grant_data", 32'(bus.latch_d), 32'(exp_q[0].data));
                    end
                end else begin
                    chk("d_stable", 32'(bus.latch_d), 32'(cap));
                end
            end else begin
                chk("idle_enable", 32'(bus.latch_enable), 32'd0);
            end
            if (bus.ack != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_onehot", 32'(bus.ack), 32'd1 << e.id);
                    chk("ack_latency", 32'(k), 32'(S + P + H + 1));
                    chk("ack_data", 32'(bus.latch_d), 32'(e.data));
                    chk("bank_q", 32'(q), 32'(e.data));
                    ack_times.push_back(cyc);
                end
            end
        end
    end

    // Variant-parameter monitor.
    int         k2 = 0;
    logic [7:0] cap2 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            k2 = 0;
        end else begin
            k2 = bus2.busy ? k2 + 1 : 0;
            if (bus2.busy) begin
                chk("v_enable_window", 32'(bus2.latch_enable), (k2 > S2 && k2 <= S2 + P2) ? 32'd1 : 32'd0);
                if (k2 == 1) cap2 = bus2.latch_d;
                else         chk("v_d_stable", 32'(bus2.latch_d), 32'(cap2));
            end else begin
                chk("v_idle_enable", 32'(bus2.latch_enable), 32'd0);
            end
            if (bus2.ack != 4'b0000) begin
                if (exp2.size() == 0) begin
                    chk("v_unexpected_ack", 32'(bus2.ack), 32'd0);
                end else begin
                    e = exp2.pop_front();
                    chk("v_ack_onehot", 32'(bus2.ack), 32'd1 << e.id);
                    chk("v_ack_latency", 32'(k2), 32'(S2 + P2 + H2 + 1));
                    chk("v_ack_data", 32'(bus2.latch_d), 32'(e.data));
                end
            end
        end
    end

    // Requesters release req on their own ack unless held permanently.
    task automatic drop_acked();
        for (int i = 0; i < 4; i++) begin
            if (bus.ack[i] && !hold_mask[i]) bus.req[i] = 1'b0;
            if (bus2.ack[i]) bus2.req[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (1) begin
            @(negedge clk);
            drop_acked();
            if (exp_q.size() == 0 && exp2.size() == 0 && !bus.busy && !bus2.busy) break;
            if (++n >= bound) begin
                chk("wait_done_timeout", 32'(n), 32'(bound + 1));
                break;
            end
        end
    endtask

    task automatic wait_ack(input int bound);
        int n = 0;
        while (1) begin
            @(negedge clk);
            drop_acked();
            if (bus.ack != 4'b0000) break;
            if (++n >= bound) begin
                chk("wait_ack_timeout", 32'(n), 32'(bound + 1));
                break;
            end
        end
    endtask

    initial begin
        bus.req = 4'hF;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus2.req = 4'h0;
        bus2.req_data = '0;

        // Reset held with all requests pending.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", 32'(bus.ack), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_enable", 32'(bus.latch_enable), 32'd0);
            chk("rst_latch_d", 32'(bus.latch_d), 32'd0);
            chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        end

        // All four at once from reset: order 0,1,2,3, six cycles apart.
        for (int i = 0; i < 4; i++) exp_q.push_back('{i, 8'(8'h11 * (i + 1))});
        reset_n = 1'b1;
        wait_done(100);
        chk("b2b_ack_count", 32'(ack_times.size()), 32'd4);
        for (int i = 0; i + 1 < ack_times.size(); i++)
            chk("b2b_spacing", 32'(ack_times[i+1] - ack_times[i]), 32'd6);
        chk("b2b_final_q", 32'(q), 32'h44);

        // Single write from requester 1.
        bus.req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
        bus.req = 4'b0010;
        exp_q.push_back('{1, 8'hA5});
        wait_done(50);
        chk("single_q", 32'(q), 32'hA5);

        // Fairness: 0 and 2 held permanently; pointer sits at 1 so 2 goes first.
        hold_mask = 4'b0101;
        bus.req_data = {8'h00, 8'h77, 8'h00, 8'h55};
        bus.req = 4'b0101;
        exp_q.push_back('{2, 8'h77});
        exp_q.push_back('{0, 8'h55});
        exp_q.push_back('{2, 8'h77});
        exp_q.push_back('{0, 8'h55});
        repeat (4) wait_ack(50);
        bus.req = 4'b0000;
        hold_mask = 4'b0000;
        wait_done(50);
        chk("fair_q", 32'(q), 32'h55);

        // Reset during the enable pulse: enable drops without a clock edge.
        bus.req_data = {8'h9C, 8'h00, 8'h00, 8'h00};
        bus.req = 4'b1000;
        begin
            int n = 0;
            while (!bus.busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("mid_busy_seen", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        chk("mid_enable_high", 32'(bus.latch_enable), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_enable", 32'(bus.latch_enable), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_ack", 32'(bus.ack), 32'd0);
        chk("async_latch_d", 32'(bus.latch_d), 32'd0);
        chk("async_grant_id", 32'(bus.grant_id), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.push_back('{3, 8'h9C});
        reset_n = 1'b1;
        wait_done(50);
        chk("rereq_q", 32'(q), 32'h9C);

        // Stretched-timing variant.
        bus2.req_data = {8'h00, 8'hBE, 8'h00, 8'h00};
        bus2.req = 4'b0100;
        exp2.push_back('{2, 8'hBE});
        wait_done(60);
        chk("variant_q", 32'(q2), 32'hBE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
